// File: rtl/multi_drop_hub.sv
// Steers a one-hot-selected bus word into one of NDROP holding registers, each with its own valid/ready consumer handshake.
// Latency: a word accepted at edge N is visible on q/q_valid right after edge N. Optional MULTI_DROP_BCAST_EN makes all-ones a broadcast.
// Backpressure: bus_ready drops only when a legal select targets a full, non-draining slot; illegal selects are always accepted and discarded.
module multi_drop_hub #(
    parameter int WIDTH = 8,
    parameter int NDROP = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       bus_data,
    input  logic [NDROP-1:0]       bus_sel,
    input  logic                   bus_valid,
    output logic                   bus_ready,
    output logic [NDROP*WIDTH-1:0] q,
    output logic [NDROP-1:0]       q_valid,
    input  logic [NDROP-1:0]       q_ready,
    input  logic                   err_clr,
    output logic                   err,
    output logic [7:0]             err_cnt
);

    localparam logic [NDROP-1:0] SEL_ONE = NDROP'(1);

    logic [NDROP-1:0] free;
    logic [NDROP-1:0] load;
    logic             one_hot;
    logic             bcast;
    logic             legal;
    logic             illegal_evt;

    // A slot that is being drained this cycle can be refilled in the same cycle.
    assign free    = ~q_valid | q_ready;
    assign one_hot = (bus_sel != '0) && ((bus_sel & (bus_sel - SEL_ONE)) == '0);

`ifdef MULTI_DROP_BCAST_EN
    assign bcast = &bus_sel;
`else
    assign bcast = 1'b0;
`endif

    assign legal       = one_hot || bcast;
    assign illegal_evt = bus_valid && !legal;

    always_comb begin
        bus_ready = 1'b1;
        load      = '0;
        if (one_hot) begin
            bus_ready = |(free & bus_sel);
        end else if (bcast) begin
            bus_ready = &free;
        end
        if (bus_valid && bus_ready && legal) begin
            load = bcast ? {NDROP{1'b1}} : bus_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= '0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            for (int i = 0; i < NDROP; i++) begin
                if (load[i]) begin
                    q[i*WIDTH +: WIDTH] <= bus_data;
                    q_valid[i]          <= 1'b1;
                end else if (q_ready[i]) begin
                    q_valid[i] <= 1'b0;
                end
            end
            // A same-cycle illegal transfer takes priority over the clear.
            if (illegal_evt) begin
                err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= 8'd1;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= 8'd0;
            end
        end
    end

endmodule
